// File: rtl/set_job_arbiter.sv
// Round-robin job arbiter that shares one circle-set counting engine.
// Issues one job at a time, returns the tagged result or a timeout error.
module set_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [16*NREQ-1:0] req_central,
  input  logic [8*NREQ-1:0] req_radius,
  output logic [NREQ-1:0]   ack,
  output logic              eng_en,
  output logic [15:0]       eng_central,
  output logic [7:0]        eng_radius,
  input  logic              eng_valid,
  input  logic [3:0]        eng_candidate,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_candidate,
  output logic              rsp_err,
  output logic [7:0]        jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            en_q, en_d;
  logic [15:0]     cen_q, cen_d;
  logic [7:0]      rad_q, rad_d;
  logic            rv_q, rv_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic [3:0]      rc_q, rc_d;
  logic            re_q, re_d;
  logic [7:0]      jd_q, jd_d;
  logic [15:0]     tmr_q, tmr_d;

  logic            found;
  logic [IDW-1:0]  gnt;
  int              idx;

  // first requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = ptr_q;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ack_d   = '0;
    en_d    = 1'b0;
    cen_d   = cen_q;
    rad_d   = rad_q;
    rv_d    = 1'b0;
    rid_d   = rid_q;
    rc_d    = rc_q;
    re_d    = re_q;
    jd_d    = jd_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gid_d   = gnt;
          cen_d   = req_central[int'(gnt)*16 +: 16];
          rad_d   = req_radius[int'(gnt)*8 +: 8];
          ack_d   = NREQ'(1) << gnt;
          en_d    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_valid) begin
          rv_d    = 1'b1;
          rid_d   = gid_q;
          rc_d    = eng_candidate;
          re_d    = 1'b0;
          jd_d    = jd_q + 8'd1;
          state_d = S_DONE;
        end else if (tmr_q == TLAST) begin
          rv_d    = 1'b1;
          rid_d   = gid_q;
          rc_d    = 4'd0;
          re_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_DONE: begin
        ptr_d   = (gid_q == IDW'(NREQ-1)) ?
                  '0 : gid_q + 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      cen_q   <= '0;
      rad_q   <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      rc_q    <= '0;
      re_q    <= 1'b0;
      jd_q    <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      cen_q   <= cen_d;
      rad_q   <= rad_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      rc_q    <= rc_d;
      re_q    <= re_d;
      jd_q    <= jd_d;
      tmr_q   <= tmr_d;
    end
  end

  assign ack           = ack_q;
  assign eng_en        = en_q;
  assign eng_central   = cen_q;
  assign eng_radius    = rad_q;
  assign rsp_valid     = rv_q;
  assign rsp_id        = rid_q;
  assign rsp_candidate = rc_q;
  assign rsp_err       = re_q;
  assign jobs_done     = jd_q;

endmodule
